// File: rtl/serial_subtractor_pkg.sv
// Shared definitions for the bit-serial subtractor: FSM state encoding and the
// half-subtractor borrow equation used by every subtractor cell.
package serial_subtractor_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  // Borrow out of x - y for a single bit with no borrow in.
  function automatic logic hs_borrow(input logic x, input logic y);
    return ~x & y;
  endfunction

endpackage

// File: rtl/serial_subtractor_fs_bit.sv
// One-bit full subtractor (a - b - bin) assembled from two half-subtractor cells
// and an OR gate; purely combinational.
module half_sub
  import serial_subtractor_pkg::*;
(
  input  logic x,
  input  logic y,
  output logic d,
  output logic bo
);

  assign d  = x ^ y;
  assign bo = hs_borrow(x, y);

endmodule

module fs_bit (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic d,
  output logic bout
);

  logic d1;
  logic b1;
  logic b2;

  half_sub u_hs_ab (
    .x  (a),
    .y  (b),
    .d  (d1),
    .bo (b1)
  );

  // The second cell subtracts the incoming borrow from the partial difference.
  half_sub u_hs_bin (
    .x  (d1),
    .y  (bin),
    .d  (d),
    .bo (b2)
  );

  assign bout = b1 | b2;

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial unsigned subtractor: diff = a - b computed LSB first over WIDTH
// clocks with a registered borrow chain and a start/busy/done handshake.
module serial_subtractor
  import serial_subtractor_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t          state;
  logic [WIDTH-1:0] sa;
  logic [WIDTH-1:0] sb;
  logic [CW-1:0]    cnt;
  logic             bff;
  logic             d;
  logic             bo;

  fs_bit u_fs (
    .a    (sa[0]),
    .b    (sb[0]),
    .bin  (bff),
    .d    (d),
    .bout (bo)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= S_IDLE;
      sa     <= '0;
      sb     <= '0;
      cnt    <= '0;
      bff    <= 1'b0;
      busy   <= 1'b0;
      done   <= 1'b0;
      diff   <= '0;
      borrow <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          done <= 1'b0;
          if (start) begin
            sa     <= a;
            sb     <= b;
            bff    <= 1'b0;
            cnt    <= '0;
            diff   <= '0;
            borrow <= 1'b0;
            busy   <= 1'b1;
            state  <= S_SHIFT;
          end
        end
        S_SHIFT: begin
          sa   <= sa >> 1;
          sb   <= sb >> 1;
          diff <= {d, diff[WIDTH-1:1]};
          bff  <= bo;
          // Counter is parked at zero on the last bit so it never passes WIDTH-1.
          if (cnt == LAST) begin
            cnt    <= '0;
            borrow <= bo;
            done   <= 1'b1;
            state  <= S_DONE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
